reg_bank_wr: RTL and testbench
==============================

Name: reg_bank_wr

Overview:
- 16-entry general register bank, write side: decodes write address/enable and updates one of 16 registers per port.
- Exposes all 16 registers as a flat bus that feeds the 16:1 read-select muxes in the datapath.
- Two write ports:
  - Port A: ALU writeback, unconditional priority.
  - Port B: load writeback, valid/ready handshake.
- r15 is the PC: it auto-advances each cycle unless written.

Parameters:
- BUS_WIDTH, 32, register width in bits (min 8).
- PC_STEP, 4, r15 increment per advancing cycle.
- PC_RESET, 0, r15 value after reset.

Ports:
- clk_in  input  1  clock, all state updates on rising edge.
- rst_n_in  input  1  synchronous active-low reset.
- wa_en_in  input  1  port A write enable.
- wa_addr_in  input  4  port A register index.
- wa_data_in  input  BUS_WIDTH  port A write data.
- wb_valid_in  input  1  port B write request.
- wb_addr_in  input  4  port B register index.
- wb_data_in  input  BUS_WIDTH  port B write data.
- wb_ready_out  output  1  port B accepted this cycle when high together with wb_valid_in.
- pc_hold_in  input  1  freeze r15 auto-advance (stall).
- regs_out  output  16*BUS_WIDTH  register contents; r(n) occupies bits [n*BUS_WIDTH +: BUS_WIDTH].
- wr_count_out  output  16  number of completed register writes (A plus accepted B), wraps at 2^16.

Behaviour:
- Reset: all of the following take effect on the rising edge while rst_n_in=0; reset overrides every write and handshake in that cycle.
  - r0..r14 = 0.
  - r15 = PC_RESET.
  - wr_count_out = 0.
  - wb_ready_out = 0 during reset.
- Write latency: one cycle. Data written at edge N is visible on regs_out after edge N. There is no write-through to the same-cycle read.
- Port A:
  - When wa_en_in=1, r[wa_addr_in] <= wa_data_in at the edge.
  - Never stalls.
- Port B handshake:
  - wb_ready_out is combinational: 1 unless wa_en_in=1 and wa_addr_in==wb_addr_in.
  - A transfer occurs when wb_valid_in and wb_ready_out are both 1.
  - Producer must hold addr/data stable while valid and not ready.
  - Valid may drop without a transfer; no state is retained.
- Simultaneous A and B:
  - Different addresses: both written in the same cycle.
  - Same address: A wins; B is stalled (ready=0) and retried.
- r15 update priority, highest first:
  1. Port A write to r15.
  2. Accepted port B write to r15.
  3. pc_hold_in=1: hold.
  4. Otherwise r15 <= r15 + PC_STEP, modulo 2^BUS_WIDTH; wraps silently.
- wr_count_out:
  - +0, +1 or +2 per cycle (A write plus B transfer).
  - Wraps modulo 2^16.
  - PC auto-advance is not counted.
- All other registers hold their value when not written.

Optional Feature:
- Macro REG_SCOREBOARD_EN.
- When defined, add the following ports:
  - lock_en_in (1): when 1, marks register lock_addr_in busy.
  - lock_addr_in (4): register index to mark busy.
  - busy_out (16): per-register busy bits.
- Busy bit behaviour:
  - Set at the edge when lock_en_in=1.
  - Cleared by an accepted port B write to that register.
  - Clear wins over set when both occur in the same cycle.
  - Port A writes do not clear busy.
  - busy_out = 0 on reset.
- When not defined: ports absent, no busy state, behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - REG_PC = 4'd15.
  - NUM_REGS = 16.
  - Register index typedef (4-bit).
- One natural sub-module: reg_wr_decode.
  - Converts {en, addr} into a 16-bit one-hot write strobe.
  - Instantiated once per port.
  - The bank combines the strobes with priority per register.

Test Plan:
1. Reset, then release with pc_hold_in=0 for 3 cycles: r15 = 0, 4, 8, 12; r0..r14 = 0; wr_count_out = 0.
2. Port A writes r3=0xDEADBEEF: regs_out r3 = 0xDEADBEEF one cycle later; wr_count_out = 1.
3. Simultaneous A(r5=0x11) and B(r6=0x22, valid): both written, wb_ready_out=1, wr_count_out +2.
4. A(r7=0xAA) and B(r7=0xBB) in the same cycle: ready=0, r7=0xAA; next cycle with A idle, B accepted and r7=0xBB.
5. Set r15=0xFFFFFFFC via port A, then one free cycle: r15 wraps to 0x00000000; with pc_hold_in=1, r15 holds.
6. With REG_SCOREBOARD_EN: lock r2 -> busy_out=0x0004; lock r2 and B-write r2 in the same cycle -> busy_out bit2=0; port A write to r2 leaves busy set.

Source files
------------

// File: rtl/reg_bank_wr_pkg.sv
// reg_bank_wr_pkg: shared constants and types for the register bank write side
package reg_bank_wr_pkg;
  localparam logic [3:0] REG_PC = 4'd15;
  localparam int NUM_REGS = 16;
  typedef logic [3:0] reg_idx_t;
endpackage

// File: rtl/reg_bank_wr_decode.sv
// reg_wr_decode: turns {en, addr} into a one-hot register write strobe
module reg_wr_decode
  import reg_bank_wr_pkg::*;
(
  input  logic                en,
  input  reg_idx_t            addr,
  output logic [NUM_REGS-1:0] strobe
);
  always_comb strobe = en ? {{(NUM_REGS-1){1'b0}}, 1'b1} << addr : '0;
endmodule

// File: rtl/reg_bank_wr.sv
// reg_bank_wr: 16-entry register bank write side, two write ports, auto-advancing r15; optional REG_SCOREBOARD_EN busy tracking
module reg_bank_wr
  import reg_bank_wr_pkg::*;
#(
  parameter int                   BUS_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0] PC_STEP   = BUS_WIDTH'(4),
  parameter logic [BUS_WIDTH-1:0] PC_RESET  = '0
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          wa_en_in,
  input  reg_idx_t                      wa_addr_in,
  input  logic [BUS_WIDTH-1:0]          wa_data_in,
  input  logic                          wb_valid_in,
  input  reg_idx_t                      wb_addr_in,
  input  logic [BUS_WIDTH-1:0]          wb_data_in,
  output logic                          wb_ready_out,
  input  logic                          pc_hold_in,
`ifdef REG_SCOREBOARD_EN
  input  logic                          lock_en_in,
  input  reg_idx_t                      lock_addr_in,
  output logic [NUM_REGS-1:0]           busy_out,
`endif
  output logic [NUM_REGS*BUS_WIDTH-1:0] regs_out,
  output logic [15:0]                   wr_count_out
);
  logic [BUS_WIDTH-1:0] r [NUM_REGS];
  logic [NUM_REGS-1:0] sa, sb;
  logic wb_go;
  always_comb wb_ready_out = rst_n_in && !(wa_en_in && wa_addr_in == wb_addr_in);
  always_comb wb_go = wb_valid_in && wb_ready_out;
  reg_wr_decode u_dec_a (.en(wa_en_in), .addr(wa_addr_in), .strobe(sa));
  reg_wr_decode u_dec_b (.en(wb_go), .addr(wb_addr_in), .strobe(sb));
  always_ff @(posedge clk_in)
    for (int i = 0; i < NUM_REGS; i++)
      if (!rst_n_in) r[i] <= (i == int'(REG_PC)) ? PC_RESET : '0;
      else if (sa[i]) r[i] <= wa_data_in;
      else if (sb[i]) r[i] <= wb_data_in;
      else if (i == int'(REG_PC) && !pc_hold_in) r[i] <= r[i] + PC_STEP;
  always_ff @(posedge clk_in)
    wr_count_out <= !rst_n_in ? '0 : wr_count_out + {15'd0, wa_en_in} + {15'd0, wb_go};
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*BUS_WIDTH +: BUS_WIDTH] = r[g];
  end
`ifdef REG_SCOREBOARD_EN
  logic [NUM_REGS-1:0] sl;
  reg_wr_decode u_dec_lock (.en(lock_en_in), .addr(lock_addr_in), .strobe(sl));
  always_ff @(posedge clk_in)
    busy_out <= !rst_n_in ? '0 : (busy_out | sl) & ~sb;
`endif
endmodule

// File: tb/tb_reg_bank_wr.sv
// tb_reg_bank_wr: scoreboard bench for reg_bank_wr with directed vectors
module tb_reg_bank_wr;
  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wa_en = 1'b0;
  logic [3:0]  wa_addr = '0;
  logic [31:0] wa_data = '0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        wb_ready;
  logic        pc_hold = 1'b0;
  logic [511:0] regs;
  logic [15:0] wr_count;
`ifdef REG_SCOREBOARD_EN
  logic        lock_en = 1'b0;
  logic [3:0]  lock_addr = '0;
  logic [15:0] busy;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];

  reg_bank_wr dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .wa_en_in(wa_en),
    .wa_addr_in(wa_addr),
    .wa_data_in(wa_data),
    .wb_valid_in(wb_valid),
    .wb_addr_in(wb_addr),
    .wb_data_in(wb_data),
    .wb_ready_out(wb_ready),
    .pc_hold_in(pc_hold),
`ifdef REG_SCOREBOARD_EN
    .lock_en_in(lock_en),
    .lock_addr_in(lock_addr),
    .busy_out(busy),
`endif
    .regs_out(regs),
    .wr_count_out(wr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_at(input int dly, input int kind, input int idx, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc = cyc + dly;
    e.kind = kind;
    e.idx = idx;
    e.val = val;
    e.name = name;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] sample(input int kind, input int idx);
    logic [31:0] v;
    v = '0;
    if (kind == 0) v = regs[idx*32 +: 32];
    else if (kind == 1) v = {16'd0, wr_count};
    else if (kind == 2) v = {31'd0, wb_ready};
`ifdef REG_SCOREBOARD_EN
    else if (kind == 3) v = {16'd0, busy};
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t rest[$];
    logic [31:0] act;
    rest = {};
    foreach (sbq[i]) begin
      if (sbq[i].cyc == cyc) begin
        act = sample(sbq[i].kind, sbq[i].idx);
        checks++;
        if (act !== sbq[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%h want=%h", sbq[i].name, cyc, act, sbq[i].val);
        end
      end else rest.push_back(sbq[i]);
    end
    sbq = rest;
  end

  initial begin
    tick();
    tick();
    for (int i = 0; i < 15; i++) expect_at(0, 0, i, 32'h0, "reset_rn");
    expect_at(0, 0, 15, 32'h0, "reset_pc");
    expect_at(0, 1, 0, 32'h0, "reset_count");
    expect_at(0, 2, 0, 32'h0, "reset_ready");
`ifdef REG_SCOREBOARD_EN
    expect_at(0, 3, 0, 32'h0, "reset_busy");
`endif
    tick();
    rst_n = 1'b1;
    expect_at(0, 0, 15, 32'h0, "pc_c0");
    expect_at(1, 0, 15, 32'h4, "pc_c1");
    expect_at(2, 0, 15, 32'h8, "pc_c2");
    expect_at(3, 0, 15, 32'hC, "pc_c3");
    expect_at(3, 1, 0, 32'h0, "count_idle");
    expect_at(0, 2, 0, 32'h1, "ready_idle");
    tick(); tick(); tick();
    wa_en = 1'b1; wa_addr = 4'd3; wa_data = 32'hDEADBEEF;
    expect_at(1, 0, 3, 32'hDEADBEEF, "a_r3");
    expect_at(1, 1, 0, 32'h1, "a_count");
    expect_at(1, 0, 15, 32'h10, "a_pc");
    tick();
    wa_addr = 4'd5; wa_data = 32'h11;
    wb_valid = 1'b1; wb_addr = 4'd6; wb_data = 32'h22;
    expect_at(0, 2, 0, 32'h1, "ab_ready");
    expect_at(1, 0, 5, 32'h11, "ab_r5");
    expect_at(1, 0, 6, 32'h22, "ab_r6");
    expect_at(1, 1, 0, 32'h3, "ab_count");
    expect_at(1, 0, 15, 32'h14, "ab_pc");
    tick();
    wa_addr = 4'd7; wa_data = 32'hAA;
    wb_addr = 4'd7; wb_data = 32'hBB;
    expect_at(0, 2, 0, 32'h0, "clash_ready");
    expect_at(1, 0, 7, 32'hAA, "clash_r7_a");
    expect_at(1, 1, 0, 32'h4, "clash_count");
    tick();
    wa_en = 1'b0;
    expect_at(0, 2, 0, 32'h1, "retry_ready");
    expect_at(1, 0, 7, 32'hBB, "retry_r7_b");
    expect_at(1, 1, 0, 32'h5, "retry_count");
    expect_at(1, 0, 15, 32'h1C, "retry_pc");
    tick();
    wa_en = 1'b1; wa_addr = 4'd15; wa_data = 32'h100;
    wb_addr = 4'd15; wb_data = 32'h200;
    expect_at(0, 2, 0, 32'h0, "pc_clash_ready");
    expect_at(1, 0, 15, 32'h100, "pc_a_wins");
    tick();
    wa_en = 1'b0;
    expect_at(1, 0, 15, 32'h200, "pc_b_write");
    expect_at(1, 1, 0, 32'h7, "pc_b_count");
    tick();
    wb_valid = 1'b0;
    wa_en = 1'b1; wa_addr = 4'd15; wa_data = 32'hFFFFFFFC;
    expect_at(1, 0, 15, 32'hFFFFFFFC, "pc_set_top");
    expect_at(1, 1, 0, 32'h8, "pc_set_count");
    tick();
    wa_en = 1'b0;
    expect_at(1, 0, 15, 32'h0, "pc_wrap");
    expect_at(1, 1, 0, 32'h8, "pc_adv_uncounted");
    tick();
    pc_hold = 1'b1;
    expect_at(1, 0, 15, 32'h0, "pc_hold1");
    expect_at(2, 0, 15, 32'h0, "pc_hold2");
    tick(); tick();
    wb_valid = 1'b1; wb_addr = 4'd15; wb_data = 32'h55;
    expect_at(1, 0, 15, 32'h55, "pc_b_over_hold");
    expect_at(1, 1, 0, 32'h9, "pc_b_hold_count");
    tick();
    wb_valid = 1'b0;
    expect_at(1, 0, 15, 32'h55, "pc_hold3");
    tick();
    pc_hold = 1'b0;
    wb_addr = 4'd9; wb_data = 32'h99;
    expect_at(1, 0, 15, 32'h59, "pc_resume");
    expect_at(1, 0, 9, 32'h0, "valid_low_no_write");
    expect_at(1, 0, 3, 32'hDEADBEEF, "r3_held");
    expect_at(1, 1, 0, 32'h9, "valid_low_count");
    tick();
`ifdef REG_SCOREBOARD_EN
    lock_en = 1'b1; lock_addr = 4'd2;
    expect_at(1, 3, 0, 32'h4, "lock_r2");
    tick();
    wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 32'h33;
    expect_at(1, 3, 0, 32'h0, "clear_beats_set");
    expect_at(1, 0, 2, 32'h33, "lock_b_r2");
    tick();
    wb_valid = 1'b0;
    expect_at(1, 3, 0, 32'h4, "relock_r2");
    tick();
    lock_en = 1'b0;
    wa_en = 1'b1; wa_addr = 4'd2; wa_data = 32'h44;
    expect_at(1, 3, 0, 32'h4, "a_keeps_busy");
    expect_at(1, 0, 2, 32'h44, "a_r2");
    tick();
    wa_en = 1'b0;
`endif
    tick(); tick();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations got=%0d want=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
